// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, 2-entry {instr, pc} buffer
// toward decode, and redirect handling that flushes the buffer and kills a stale response.
module fetch_unit #(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            dec_valid,
  output logic [31:0]     dec_instr,
  output logic [PC_W-1:0] dec_pc,
  input  logic            dec_ready
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_KILL} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] req_pc_q;
  logic [31:0]     instr_q [2];
  logic [PC_W-1:0] epc_q   [2];
  logic            rd_ptr_q, wr_ptr_q;
  logic [1:0]      count_q;

  logic            push, pop, issue;
  logic [2:0]      proj_count;

  // Issue only when the buffer still has room after this cycle's push/pop.
  always_comb begin
    push       = rst_n && (state_q == S_WAIT) && imem_rvalid && !redirect_valid;
    pop        = (count_q != 2'd0) && dec_ready && !redirect_valid;
    proj_count = {1'b0, count_q} + {2'b00, push} - {2'b00, pop};
    issue      = rst_n && !redirect_valid &&
                 ((state_q == S_FETCH) || ((state_q == S_WAIT) && imem_rvalid)) &&
                 (proj_count < 3'd2);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = ((state_q != S_FETCH) && !imem_rvalid) ? S_KILL : S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: if (issue)       state_d = S_WAIT;
        S_WAIT:  if (imem_rvalid) state_d = issue ? S_WAIT : S_FETCH;
        S_KILL:  if (imem_rvalid) state_d = S_FETCH;
        default:                  state_d = S_FETCH;
      endcase
    end
  end

  always_comb begin
    imem_req  = issue;
    imem_addr = pc_q;
    dec_valid = (count_q != 2'd0);
    dec_instr = instr_q[rd_ptr_q];
    dec_pc    = epc_q[rd_ptr_q];
  end

  // Redirect flushes by collapsing the write pointer onto the read pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      count_q  <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        instr_q[i] <= '0;
        epc_q[i]   <= '0;
      end
    end else if (redirect_valid) begin
      pc_q     <= redirect_pc;
      count_q  <= '0;
      wr_ptr_q <= rd_ptr_q;
    end else begin
      if (issue) begin
        req_pc_q <= pc_q;
        pc_q     <= pc_q + PC_W'(1);
      end
      if (push) begin
        instr_q[wr_ptr_q] <= imem_rdata;
        epc_q[wr_ptr_q]   <= req_pc_q;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural imem with configurable latency,
// expected {pc} scoreboard compared against observed decode transfers.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [15:0] dec_pc;
  logic        dec_ready = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .dec_ready(dec_ready)
  );

  typedef struct {
    logic [15:0] pc;
    logic [31:0] instr;
    int          cyc;
  } xfer_t;

  xfer_t       obs_q[$];
  logic [15:0] exp_q[$];
  int checks = 0, failures = 0, cyc = 0, viol = 0;
  int mem_lat = 1, mem_cnt = 0;
  bit mem_busy = 1'b0, force_rv = 1'b0;
  logic [15:0] mem_addr = '0;
  logic        s_req, s_valid;
  logic [15:0] s_addr, s_pc;
  logic [31:0] s_instr;

  // One clock cycle: drive inputs on the falling edge, sample #1 later, then
  // record decode transfers and new memory requests.
  task automatic step(input bit rst, input bit rdy, input bit redir, input logic [15:0] rpc);
    @(negedge clk);
    rst_n = rst; dec_ready = rdy; redirect_valid = redir; redirect_pc = rpc;
    imem_rvalid = 1'b0; imem_rdata = '0;
    if (mem_busy) begin
      if (mem_cnt <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hA000_0000 + {16'h0000, mem_addr};
        mem_busy    = 1'b0;
      end else mem_cnt--;
    end
    if (force_rv) begin imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; end
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = dec_valid; s_pc = dec_pc; s_instr = dec_instr;
    if (s_valid && rdy && !redir && rst) obs_q.push_back('{s_pc, s_instr, cyc});
    if (s_req) begin
      if (mem_busy) viol++;
      mem_busy = 1'b1; mem_addr = s_addr; mem_cnt = mem_lat;
    end
    cyc++;
  endtask

  task automatic do_reset();
    mem_busy = 1'b0; force_rv = 1'b0; viol = 0;
    obs_q.delete(); exp_q.delete();
    step(0, 0, 0, 16'h0); step(0, 0, 0, 16'h0);
  endtask

  task automatic test_reset();
    mem_lat = 1;
    do_reset();
    checks++; if (s_req !== 1'b0)     begin failures++; $display("FAIL reset_req: got %b expected 0", s_req); end
    checks++; if (s_valid !== 1'b0)   begin failures++; $display("FAIL reset_valid: got %b expected 0", s_valid); end
    checks++; if (s_pc !== 16'h0)     begin failures++; $display("FAIL reset_pc: got %h expected 0000", s_pc); end
    checks++; if (s_instr !== 32'h0)  begin failures++; $display("FAIL reset_instr: got %h expected 0", s_instr); end
    step(1, 1, 0, 16'h0);
    checks++; if (s_req !== 1'b1)     begin failures++; $display("FAIL first_req: got %b expected 1", s_req); end
    checks++; if (s_addr !== 16'h0)   begin failures++; $display("FAIL first_addr: got %h expected 0000", s_addr); end
  endtask

  task automatic test_stream();
    int start; xfer_t o; logic [15:0] e;
    mem_lat = 1;
    do_reset();
    start = cyc;
    for (int i = 0; i < 10; i++) exp_q.push_back(16'(i));
    repeat (12) step(1, 1, 0, 16'h0);
    checks++; if (obs_q.size() !== 10) begin failures++; $display("FAIL stream_count: got %0d expected 10", obs_q.size()); end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL stream_missing: got none expected pc %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o.pc !== e || o.instr !== 32'hA000_0000 + {16'h0, e}) begin
          failures++; $display("FAIL stream_data: got pc %h instr %h expected pc %h", o.pc, o.instr, e);
        end
        checks++; if (o.cyc !== start + 2 + i) begin failures++; $display("FAIL stream_timing: got cycle %0d expected %0d", o.cyc, start + 2 + i); end
      end
    end
    checks++; if (viol !== 0) begin failures++; $display("FAIL stream_outstanding: got %0d expected 0", viol); end
  endtask

  task automatic test_stall();
    int start; xfer_t o; logic [15:0] e;
    mem_lat = 1;
    do_reset();
    start = cyc;
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 16'h0);
      if (i >= 3) begin
        checks++; if (s_req !== 1'b0) begin failures++; $display("FAIL stall_req: got %b expected 0", s_req); end
        checks++; if (s_valid !== 1'b1 || s_pc !== 16'h0 || s_instr !== 32'hA000_0000) begin
          failures++; $display("FAIL stall_head: got v=%b pc %h instr %h expected v=1 pc 0000 instr a0000000", s_valid, s_pc, s_instr);
        end
      end
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(16'(i));
    repeat (4) step(1, 1, 0, 16'h0);
    checks++; if (obs_q.size() !== 4) begin failures++; $display("FAIL stall_count: got %0d expected 4", obs_q.size()); end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL stall_missing: got none expected pc %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o.pc !== e || o.cyc !== start + 6 + i) begin
          failures++; $display("FAIL stall_order: got pc %h cycle %0d expected pc %h cycle %0d", o.pc, o.cyc, e, start + 6 + i);
        end
      end
    end
    checks++; if (viol !== 0) begin failures++; $display("FAIL stall_outstanding: got %0d expected 0", viol); end
  endtask

  task automatic test_redirect_kill();
    int r, first_req_cyc, first_valid_cyc; bit found; logic [15:0] first_req_addr, e; xfer_t o;
    mem_lat = 3;
    do_reset();
    for (int i = 0; i < 4; i++) exp_q.push_back(16'(i));
    exp_q.push_back(16'h0040); exp_q.push_back(16'h0041);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1, 1, 0, 16'h0);
      if (s_req && s_addr == 16'h0005) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL kill_setup: got no request to 0005 expected one"); end
    r = cyc;
    step(1, 1, 1, 16'h0040);
    first_req_cyc = -1; first_valid_cyc = -1; first_req_addr = '0;
    for (int i = 0; i < 20 && first_valid_cyc < 0; i++) begin
      step(1, 1, 0, 16'h0);
      if (s_req && first_req_cyc < 0) begin first_req_cyc = cyc - 1; first_req_addr = s_addr; end
      if (s_valid) first_valid_cyc = cyc - 1;
    end
    checks++; if (first_req_cyc !== r + 3 || first_req_addr !== 16'h0040) begin
      failures++; $display("FAIL kill_req: got cycle %0d addr %h expected cycle %0d addr 0040", first_req_cyc, first_req_addr, r + 3);
    end
    checks++; if (first_valid_cyc !== r + 7) begin
      failures++; $display("FAIL kill_valid_gap: got cycle %0d expected %0d", first_valid_cyc, r + 7);
    end
    repeat (4) step(1, 1, 0, 16'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL kill_missing: got none expected pc %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o.pc !== e || o.instr !== 32'hA000_0000 + {16'h0, e}) begin
          failures++; $display("FAIL kill_order: got pc %h instr %h expected pc %h", o.pc, o.instr, e);
        end
      end
    end
    checks++; if (viol !== 0) begin failures++; $display("FAIL kill_outstanding: got %0d expected 0", viol); end
  endtask

  task automatic test_wrap();
    int r; xfer_t o; logic [15:0] e;
    mem_lat = 1;
    do_reset();
    repeat (3) step(1, 1, 0, 16'h0);
    r = cyc;
    step(1, 1, 1, 16'hFFFE);
    obs_q.delete();
    exp_q.push_back(16'hFFFE); exp_q.push_back(16'hFFFF); exp_q.push_back(16'h0000); exp_q.push_back(16'h0001);
    repeat (6) step(1, 1, 0, 16'h0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL wrap_missing: got none expected pc %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o.pc !== e || o.instr !== 32'hA000_0000 + {16'h0, e} || o.cyc !== r + 3 + i) begin
          failures++; $display("FAIL wrap_seq: got pc %h instr %h cycle %0d expected pc %h cycle %0d", o.pc, o.instr, o.cyc, e, r + 3 + i);
        end
      end
    end
  endtask

  task automatic test_back_to_back_redirect();
    xfer_t o; logic [15:0] e;
    mem_lat = 1;
    do_reset();
    repeat (4) step(1, 0, 0, 16'h0);
    checks++; if (s_valid !== 1'b1) begin failures++; $display("FAIL coinc_setup: got valid %b expected 1", s_valid); end
    force_rv = 1'b1;
    step(1, 1, 1, 16'h0123);
    force_rv = 1'b0;
    obs_q.delete();
    step(1, 1, 0, 16'h0);
    checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL coinc_flush: got valid %b expected 0", s_valid); end
    checks++; if (s_req !== 1'b1 || s_addr !== 16'h0123) begin
      failures++; $display("FAIL coinc_req: got req %b addr %h expected req 1 addr 0123", s_req, s_addr);
    end
    exp_q.push_back(16'h0123); exp_q.push_back(16'h0124);
    repeat (3) step(1, 1, 0, 16'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL coinc_missing: got none expected pc %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o.pc !== e || o.instr !== 32'hA000_0000 + {16'h0, e}) begin
          failures++; $display("FAIL coinc_order: got pc %h instr %h expected pc %h", o.pc, o.instr, e);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    xfer_t o; logic [15:0] e;
    mem_lat = 1;
    do_reset();
    repeat (4) step(1, 0, 0, 16'h0);
    mem_busy = 1'b0;
    step(0, 1, 0, 16'h0);
    obs_q.delete();
    step(1, 1, 0, 16'h0);
    checks++; if (s_valid !== 1'b0 || s_pc !== 16'h0) begin
      failures++; $display("FAIL midreset_valid: got valid %b pc %h expected valid 0 pc 0000", s_valid, s_pc);
    end
    checks++; if (s_req !== 1'b1 || s_addr !== 16'h0000) begin
      failures++; $display("FAIL midreset_req: got req %b addr %h expected req 1 addr 0000", s_req, s_addr);
    end
    for (int i = 0; i < 3; i++) exp_q.push_back(16'(i));
    repeat (4) step(1, 1, 0, 16'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL midreset_missing: got none expected pc %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o.pc !== e) begin failures++; $display("FAIL midreset_order: got pc %h expected pc %h", o.pc, e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_kill();
    test_wrap();
    test_back_to_back_redirect();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
